// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, Tuse/Tnew encodings and the per-stage hazard record.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [2:0] TUSE_0    = 3'd0;
  localparam logic [2:0] TUSE_1    = 3'd1;
  localparam logic [2:0] TUSE_2    = 3'd2;
  // Operand not read: larger than any Tnew, so it can never stall.
  localparam logic [2:0] TUSE_NONE = 3'd7;

  localparam logic [2:0] TNEW_0 = 3'd0;
  localparam logic [2:0] TNEW_1 = 3'd1;
  localparam logic [2:0] TNEW_2 = 3'd2;

  typedef enum logic [1:0] {
    MD_NONE,
    MD_MUL,
    MD_DIV,
    MD_HILO
  } md_kind_t;

  typedef struct packed {
    logic [4:0] waddr;
    logic [2:0] tnew;
    logic       is_md;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  function automatic logic [2:0] tnew_step(input logic [2:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 3'd1;
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational D-stage classifier: destination, Tnew, per-operand Tuse/source and mult/div class.
// Unread operands report source register 0 and TUSE_NONE.
module instr_class
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  waddr,
  output logic [2:0]  tnew,
  output logic [4:0]  src_rs,
  output logic [4:0]  src_rt,
  output logic [2:0]  tuse_rs,
  output logic [2:0]  tuse_rt,
  output logic        is_md,
  output md_kind_t    md_kind
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign fn = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    waddr   = 5'd0;
    tnew    = TNEW_0;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    md_kind = MD_NONE;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: begin
            waddr   = rd;
            tnew    = TNEW_1;
            tuse_rs = TUSE_1;
            tuse_rt = TUSE_1;
          end
          FN_JR: tuse_rs = TUSE_0;
          FN_MULT, FN_MULTU: begin
            tuse_rs = TUSE_1;
            tuse_rt = TUSE_1;
            md_kind = MD_MUL;
          end
          FN_DIV, FN_DIVU: begin
            tuse_rs = TUSE_1;
            tuse_rt = TUSE_1;
            md_kind = MD_DIV;
          end
          FN_MFHI, FN_MFLO: begin
            waddr   = rd;
            tnew    = TNEW_1;
            md_kind = MD_HILO;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs = TUSE_1;
            md_kind = MD_HILO;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDI, OP_ADDIU, OP_SLTI: begin
        waddr   = rt;
        tnew    = TNEW_1;
        tuse_rs = TUSE_1;
      end
      OP_LUI: begin
        waddr = rt;
        tnew  = TNEW_1;
      end
      OP_LW: begin
        waddr   = rt;
        tnew    = TNEW_2;
        tuse_rs = TUSE_1;
      end
      OP_SW: begin
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      OP_BEQ, OP_BNE: begin
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        waddr = 5'd31;
        tnew  = TNEW_0;
      end
      default: ;
    endcase
  end

  assign src_rs = (tuse_rs == TUSE_NONE) ? 5'd0 : rs;
  assign src_rt = (tuse_rt == TUSE_NONE) ? 5'd0 : rt;
  assign is_md  = (md_kind != MD_NONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: combinational stall/forward selects for the D instruction from NSTAGE
// tracked stage records, plus the mult/div busy counter. Stall holds D and bubbles stage 1.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter  int NSTAGE  = 3,
  parameter  int MUL_CYC = 5,
  parameter  int DIV_CYC = 10,
  localparam int SW      = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   instr_d,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_rs,
  output logic [SW-1:0] fwd_rt,
  output logic          md_busy
);

  localparam int MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [4:0]  d_waddr;
  logic [2:0]  d_tnew;
  logic [4:0]  d_src_rs;
  logic [4:0]  d_src_rt;
  logic [2:0]  d_tuse_rs;
  logic [2:0]  d_tuse_rt;
  logic        d_is_md;
  md_kind_t    d_kind;

  stage_rec_t [NSTAGE:1] stg;
  stage_rec_t  dec_rec;
  logic        e_div;
  logic [CW-1:0] md_cnt;

  logic [SW:0] rs_scan;
  logic [SW:0] rt_scan;
  logic        busy_raw;
  logic        stall_raw;
  logic        bubble;

  instr_class u_class (
    .instr   (instr_d),
    .waddr   (d_waddr),
    .tnew    (d_tnew),
    .src_rs  (d_src_rs),
    .src_rt  (d_src_rt),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .is_md   (d_is_md),
    .md_kind (d_kind)
  );

  // Returns {stall, select}: stall is judged on the nearest writer only,
  // select is the nearest writer whose result is already available.
  function automatic logic [SW:0] scan(input stage_rec_t [NSTAGE:1] s,
                                       input logic [4:0] src,
                                       input logic [2:0] tuse);
    logic          hit;
    logic          stl;
    logic [SW-1:0] sel;
    hit = 1'b0;
    stl = 1'b0;
    sel = '0;
    for (int k = 1; k <= NSTAGE; k++) begin
      if (src != 5'd0 && s[k].waddr == src) begin
        if (!hit) stl = (s[k].tnew > tuse);
        if (sel == '0 && s[k].tnew == TNEW_0) sel = SW'(k);
        hit = 1'b1;
      end
    end
    return {stl, sel};
  endfunction

  always_comb begin
    dec_rec       = BUBBLE;
    dec_rec.waddr = d_waddr;
    dec_rec.tnew  = d_tnew;
    dec_rec.is_md = (d_kind == MD_MUL) || (d_kind == MD_DIV);
  end

  assign rs_scan   = scan(stg, d_src_rs, d_tuse_rs);
  assign rt_scan   = scan(stg, d_src_rt, d_tuse_rt);
  assign busy_raw  = (md_cnt != '0);
  assign stall_raw = rs_scan[SW] | rt_scan[SW] | (d_is_md & (busy_raw | stg[1].is_md));
  assign bubble    = stall_raw | flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= NSTAGE; k++) stg[k] <= BUBBLE;
      e_div  <= 1'b0;
      md_cnt <= '0;
    end else begin
      stg[1] <= bubble ? BUBBLE : dec_rec;
      e_div  <= !bubble && (d_kind == MD_DIV);
      for (int k = 2; k <= NSTAGE; k++) begin
        stg[k].waddr <= stg[k-1].waddr;
        stg[k].tnew  <= tnew_step(stg[k-1].tnew);
        stg[k].is_md <= stg[k-1].is_md;
      end
      // The unit starts as the mult/div moves from stage 1 to stage 2.
      if (stg[1].is_md) md_cnt <= e_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      else if (busy_raw) md_cnt <= md_cnt - CW'(1);
    end
  end

  assign stall   = reset_n & stall_raw;
  assign fwd_rs  = reset_n ? rs_scan[SW-1:0] : '0;
  assign fwd_rt  = reset_n ? rt_scan[SW-1:0] : '0;
  assign md_busy = reset_n & busy_raw;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NSTAGE, default 3, number of tracked stages after D (1=E, 2=M, 3=W), legal range 2..6.
REQ-002 Parameter MUL_CYC, default 5, busy cycles for mult/multu.
REQ-003 Parameter DIV_CYC, default 10, busy cycles for div/divu.
REQ-004 Parameter SW, derived as clog2(NSTAGE+1), width of each forward select.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 instr_d  in  32  instruction in D; 32'h0 is a nop.
REQ-008 flush  in  1  kills the D instruction, e.g. a taken-branch squash; a bubble enters stage 1.
REQ-009 stall  out  1  holds PC and the D register; a bubble enters stage 1.
REQ-010 fwd_rs  out  SW  rs source: 0 = GRF, k = stage k result.
REQ-011 fwd_rt  out  SW  rt source, same encoding as fwd_rs.
REQ-012 md_busy  out  1  mult/div unit occupied.

Function
REQ-013 Shall keep a per-stage record {waddr[4:0], tnew[2:0], is_md}; stage k+1 loads stage k each cycle, and stage 1 loads the decoded D instruction, or a bubble (waddr=0) on stall or flush.
REQ-014 Decode shall use these rules:
- addu/subu/and/or/xor/slt: waddr=rd, tnew=1.
- ori/addi/addiu/lui/slti: waddr=rt, tnew=1.
- lw: waddr=rt, tnew=2.
- jal: waddr=31, tnew=0.
- mfhi/mflo: waddr=rd, tnew=1.
- All other instructions: waddr=0.
REQ-015 tnew shall decrement by 1 per stage advance, saturating at 0.
REQ-016 Tuse shall be:
- rs: beq/bne/jr = 0; all other rs readers = 1.
- rt: beq/bne = 0; R-type ALU and mult/div = 1; sw = 2.
- Unused operands shall never stall or forward.
REQ-017 stall shall be combinational and asserted when, for an operand with src!=0, the lowest-index stage k with waddr==src has tnew>Tuse.
REQ-018 For each operand, fwd shall equal the lowest k with waddr==src!=0 and tnew==0, and 0 if no such stage exists; the nearest stage shall win on multiple matches.
REQ-019 Register 0 shall never stall or forward.
REQ-020 When a mult/multu/div/divu leaves stage 1 to stage 2, a busy counter shall load MUL_CYC or DIV_CYC respectively; md_busy = (counter != 0), and the counter shall decrement each cycle to 0.
REQ-021 stall shall also assert when D holds mult/div/mfhi/mflo/mthi/mtlo and either md_busy=1 or stage 1 is_md=1.
REQ-022 When stall and flush are simultaneous, flush shall win: a bubble is inserted, and stall remains a pure output.
REQ-023 The busy counter shall continue counting during stall and flush.

Reset
REQ-024 While reset_n=0 at a clock edge, all stage records, tnew and is_md shall clear to 0 and the counter shall clear to 0.
REQ-025 While reset_n=0, stall=0, fwd_rs=0, fwd_rt=0 and md_busy=0 shall hold.
REQ-026 Reset asserted mid-divide shall abort the divide, and md_busy shall be 0 on the following cycle.

Structure
REQ-027 Opcode/funct constants, the Tuse/Tnew encodings and the stage-record struct shall live in the shared package mips_pkg.
REQ-028 A combinational sub-module instr_class (instr -> waddr, tnew, tuse_rs, tuse_rt, is_md, md_kind) shall be instantiated for stage 1 decode.
REQ-029 The stage records shall be a parametrised array indexed 1..NSTAGE, with no per-stage hand-written code.

Verification
REQ-030 lw $1 followed by addu $2,$1,$3 -> one stall cycle, then fwd_rs=2 (M) for the addu in E-use.
REQ-031 addu $1 followed by beq $1,$0 -> one stall cycle, then fwd_rs=1? no: fwd_rs=2 after the advance; the bench shall also check the no-stall case ori $1 ; nop ; beq $1 -> fwd_rs=2, stall=0.
REQ-032 jal followed by jr $31 -> stall=0 and fwd_rs=1.
REQ-033 div followed by mflo with DIV_CYC=10 -> stall asserted while md_busy=1, the mflo issues on the first cycle md_busy=0, and md_busy is low after 10 cycles.
REQ-034 addu $0,... followed by a reader of $0 -> stall=0 and fwd=0; addu $5 in both E and M -> fwd=1 (nearest).
REQ-035 reset_n=0 during div with lw in M -> next cycle md_busy=0, stall=0, all fwd=0; rerun REQ-030 with NSTAGE=5 and require identical results.
